risc_core_param: RTL
====================

// Module: risc_core_param
// PURPOSE
//  Parametrised multicycle successor of the lab 16-bit simple RISC machine.
//  Executes MOV/ADD/CMP/AND/MVN/HALT from an external synchronous instruction
//  memory, with configurable data and PC width.
//  Adds NZV status flags, CMP, start/halted/illegal handshake and single-step.
//  Sits between the instruction ROM and top-level display/debug logic.
// PARAMETERS
//  DATA_W   16  datapath, register and out width (>=8); imm8 is sign-extended to DATA_W
//  PC_W      8  program counter / imem address width; PC wraps modulo 2**PC_W
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       1-cycle pulse in IDLE: load PC and begin execution
//  start_pc    in   PC_W    first instruction address, sampled with start
//  imem_addr   out  PC_W    instruction address, equal to PC
//  imem_rdata  in   16      instruction, valid 1 cycle after imem_addr
//  out         out  DATA_W  last value written to any register (signed)
//  flags       out  3       {N,Z,V} status
//  halted      out  1       1 while in HALT state
//  illegal     out  1       1 when the halt was caused by an undefined opcode
//  step        in   1       only present with RISC_STEP_EN
// BEHAVIOUR
//  Reset (async): state=IDLE, PC=0, R0..R7=0, IR=0, out=0, flags=0,
//   halted=0, illegal=0. Reset mid-instruction aborts it; no write occurs.
//  Encoding: [15:13]opc [12:11]op [10:8]Rn [7:5]Rd [4:3]sh [2:0]Rm.
//   110/10 MOV Rn,#imm8 | 110/00 MOV Rd,Rm{sh}
//   101/00 ADD Rd,Rn,Rm{sh} | 101/01 CMP Rn,Rm{sh}
//   101/10 AND Rd,Rn,Rm{sh} | 101/11 MVN Rd,Rm{sh}
//   111/xx HALT | anything else: illegal
//  sh: 00 none, 01 LSL1, 10 LSR1 (shift in 0), 11 ASR1 (copy MSB).
//  States: IDLE, IF1, IF2, UPC, DEC, GETA, GETB, EXEC, WB, HALT (+WAIT).
//  IDLE --start--> IF1 (PC<=start_pc). IF1: present PC. IF2: IR<=imem_rdata.
//   UPC: PC<=PC+1. DEC: dispatch by opcode.
//  Cycles per instruction, counted from IF1:
//   MOV imm  IF1 IF2 UPC DEC WB                  = 5
//   MOV sh   IF1 IF2 UPC DEC GETB EXEC WB        = 7
//   MVN      IF1 IF2 UPC DEC GETB EXEC WB        = 7
//   ADD/AND  IF1 IF2 UPC DEC GETA GETB EXEC WB   = 8
//   CMP      IF1 IF2 UPC DEC GETA GETB EXEC      = 7 (no register write)
//   HALT/illegal  DEC -> HALT. HALT is exited only by rst.
//  WB: Rd (Rn for MOV imm) <= result; out <= result in the same cycle.
//  Arithmetic: DATA_W bits, wraps. CMP computes Rn - Rm'.
//   ADD and CMP update N=MSB, Z=(res==0), V=signed overflow.
//   MOV, AND and MVN leave flags unchanged.
//  start outside IDLE is ignored. PC wraps from 2**PC_W-1 to 0.
// CONFIGURATION
//  RISC_STEP_EN defined:
//   - adds the step port.
//   - after WB (or after EXEC for CMP), the core waits in WAIT until step==1,
//     then goes to IF1.
//   - rst in WAIT returns the core to IDLE.
//  RISC_STEP_EN undefined: no step port; WB/EXEC goes directly to IF1.
// TESTING
//  T1 DATA_W=16. ROM@0: MOV R0,#78; MOV R1,R0,LSR; AND R2,R0,R1; HALT.
//   start_pc=0 -> out=78@5, 39@12, 6@20; halted=1 at cycle 24; illegal=0.
//  T2 ROM@4: MOV R0,#56; MOV R1,#-17; ADD R0,R0,R1; CMP R0,R0; MVN R2,R0.
//   -> out 56, -17, 39; flags {N,Z,V}=010 after CMP; out=-40 after MVN.
//  T3 DATA_W=8: MOV R0,#-128; MOV R1,#127; CMP R0,R1 -> flags=001, out=127.
//  T4 DATA_W=32: MOV R0,#-1; ADD R1,R0,R0 -> out=32'hFFFFFFFE, flags=100.
//  T5 word 16'h0000 at start_pc=8'hFF -> PC wraps to 0, halted=1, illegal=1.
//   Then rst high in the middle of an ADD -> out=0, halted=0, IDLE.
//  T6 RISC_STEP_EN: T1 program -> core stalls after each WB until step;
//   out holds 78 until the first step pulse.

Source files
------------

// File: rtl/risc_core_param_if.sv
// ============================================================================
// Module  : risc_core_param_if
// Brief   : Start/debug handshake and instruction-memory bus of risc_core_param.
//           The step signal exists only when RISC_STEP_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface risc_core_param_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
);
    logic              start;
    logic [PC_W-1:0]   start_pc;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic [DATA_W-1:0] out;
    logic [2:0]        flags;
    logic              halted;
    logic              illegal;
`ifdef RISC_STEP_EN
    logic              step;

    modport master (output start, start_pc, imem_rdata, step,
                    input  imem_addr, out, flags, halted, illegal);
    modport slave  (input  start, start_pc, imem_rdata, step,
                    output imem_addr, out, flags, halted, illegal);
`else
    modport master (output start, start_pc, imem_rdata,
                    input  imem_addr, out, flags, halted, illegal);
    modport slave  (input  start, start_pc, imem_rdata,
                    output imem_addr, out, flags, halted, illegal);
`endif
endinterface

`default_nettype wire

// File: rtl/risc_core_param.sv
// ============================================================================
// Module  : risc_core_param
// Brief   : Parametrised multicycle RISC core (MOV/ADD/CMP/AND/MVN/HALT) with
//           NZV flags. Define RISC_STEP_EN to add single-step via bus.step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module risc_core_param #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    risc_core_param_if.slave bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_IF1  = 4'd1;
    localparam logic [3:0] S_IF2  = 4'd2;
    localparam logic [3:0] S_UPC  = 4'd3;
    localparam logic [3:0] S_DEC  = 4'd4;
    localparam logic [3:0] S_GETA = 4'd5;
    localparam logic [3:0] S_GETB = 4'd6;
    localparam logic [3:0] S_EXEC = 4'd7;
    localparam logic [3:0] S_WB   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;
`ifdef RISC_STEP_EN
    localparam logic [3:0] S_WAIT = 4'd10;
    localparam logic [3:0] S_NEXT = S_WAIT;
`else
    localparam logic [3:0] S_NEXT = S_IF1;
`endif

    logic [3:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] a_q, b_q, res_q, out_q;
    logic [2:0]        flags_q;
    logic              illegal_q;

    logic [2:0]        opc, rn, rd, rm;
    logic [1:0]        op, sh;
    logic              is_movi, is_movs, is_alu, is_cmp, is_mvn, is_halt, is_bad;
    logic [DATA_W-1:0] imm_ext, rm_val, rm_sh, sum, diff, exec_res;
    logic              add_v, sub_v;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign is_movi = (opc == 3'b110) && (op == 2'b10);
    assign is_movs = (opc == 3'b110) && (op == 2'b00);
    assign is_alu  = (opc == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign is_halt = (opc == 3'b111);
    assign is_bad  = !(is_movi || is_movs || is_alu || is_halt);

    assign imm_ext = DATA_W'($signed(ir_q[7:0]));
    assign rm_val  = rf_q[rm];
    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;
    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and result sign flips.
    assign add_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1]  != a_q[DATA_W-1]);
    assign sub_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);

    always_comb begin
        rm_sh = rm_val;
        case (sh)
            2'b01:   rm_sh = {rm_val[DATA_W-2:0], 1'b0};
            2'b10:   rm_sh = {1'b0, rm_val[DATA_W-1:1]};
            2'b11:   rm_sh = {rm_val[DATA_W-1], rm_val[DATA_W-1:1]};
            default: rm_sh = rm_val;
        endcase
    end

    always_comb begin
        exec_res = sum;
        if (!is_alu) begin
            exec_res = b_q;
        end else begin
            case (op)
                2'b10:   exec_res = a_q & b_q;
                2'b11:   exec_res = ~b_q;
                default: exec_res = sum;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                if (is_movi)                state_d = S_WB;
                else if (is_movs || is_mvn) state_d = S_GETB;
                else if (is_alu)            state_d = S_GETA;
                else                        state_d = S_HALT;
            end
            S_GETA: state_d = S_GETB;
            S_GETB: state_d = S_EXEC;
            S_EXEC: state_d = is_cmp ? S_NEXT : S_WB;
            S_WB:   state_d = S_NEXT;
`ifdef RISC_STEP_EN
            S_WAIT: if (bus.step) state_d = S_IF1;
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_addr = pc_q;
        bus.halted    = (state_q == S_HALT);
        bus.illegal   = illegal_q;
        bus.out       = out_q;
        bus.flags     = flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            out_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) pc_q <= bus.start_pc;
                S_IF2:  ir_q <= bus.imem_rdata;
                S_UPC:  pc_q <= pc_q + PC_W'(1);
                S_DEC: begin
                    if (is_movi) res_q <= imm_ext;
                    if (is_bad)  illegal_q <= 1'b1;
                end
                S_GETA: a_q <= rf_q[rn];
                S_GETB: b_q <= rm_sh;
                S_EXEC: begin
                    res_q <= exec_res;
                    if (is_alu && op == 2'b00)
                        flags_q <= {sum[DATA_W-1], sum == '0, add_v};
                    else if (is_cmp)
                        flags_q <= {diff[DATA_W-1], diff == '0, sub_v};
                end
                S_WB: begin
                    rf_q[is_movi ? rn : rd] <= res_q;
                    out_q <= res_q;
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire
